// File: rtl/systolic_input_skewer_if.sv
// Edge-feed bus between a tile sequencer and the systolic input skewer.
// The master drives tile control and beats; the slave returns the skewed wavefront.
interface systolic_input_skewer_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic                 start;
    logic [CNT_W-1:0]     k_len;
    logic                 in_valid;
    logic                 in_ready;
    logic [N*WIDTH-1:0]   in_data;
    logic [N*WIDTH-1:0]   out_data;
    logic [N-1:0]         out_first;
    logic                 busy;
    logic                 done;

    modport master (
        output start, k_len, in_valid, in_data,
        input  in_ready, out_data, out_first, busy, done
    );

    modport slave (
        input  start, k_len, in_valid, in_data,
        output in_ready, out_data, out_first, busy, done
    );
endinterface

// File: rtl/systolic_input_skewer.sv
// Delays lane i of each accepted FP8 beat by i cycles to build the diagonal wavefront
// for one PE-array edge, tagging the tile's first beat and zero-filling bubbles and drain.
module systolic_input_skewer #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    systolic_input_skewer_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} state_t;

    localparam int               DW         = $clog2(N + 1);
    localparam logic [DW-1:0]    DRAIN_INIT = DW'((N > 1) ? (N - 2) : 0);
    localparam logic [DW-1:0]    DRAIN_ONE  = DW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_k_len, w_k_len_next;
    logic [CNT_W-1:0]   r_beat_cnt, w_beat_cnt_next;
    logic [DW-1:0]      r_drain_cnt, w_drain_cnt_next;
    logic               r_done, w_done_next;
    logic [N*WIDTH-1:0] w_push_data;
    logic               w_push_first;
    logic [N*WIDTH-1:0] w_out_data;
    logic [N-1:0]       w_out_first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_k_len     <= '0;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_k_len     <= w_k_len_next;
            r_beat_cnt  <= w_beat_cnt_next;
            r_drain_cnt <= w_drain_cnt_next;
            r_done      <= w_done_next;
        end
    end

    // Anything not an accepted beat pushes zeros, so bubbles and the drain tail add nothing.
    always_comb begin
        w_state_next     = r_state;
        w_k_len_next     = r_k_len;
        w_beat_cnt_next  = r_beat_cnt;
        w_drain_cnt_next = r_drain_cnt;
        w_done_next      = 1'b0;
        w_push_data      = '0;
        w_push_first     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && (bus.k_len != '0)) begin
                    w_k_len_next    = bus.k_len;
                    w_beat_cnt_next = '0;
                    w_state_next    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.in_valid) begin
                    w_push_data     = bus.in_data;
                    w_push_first    = (r_beat_cnt == '0);
                    w_beat_cnt_next = r_beat_cnt + CNT_ONE;
                    if ((r_beat_cnt + CNT_ONE) == r_k_len) begin
                        if (N > 1) begin
                            w_state_next     = S_DRAIN;
                            w_drain_cnt_next = DRAIN_INIT;
                        end else begin
                            w_state_next = S_IDLE;
                            w_done_next  = 1'b1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == '0) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_drain_cnt_next = r_drain_cnt - DRAIN_ONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Lane gi is a chain of gi+1 registers; element and first bit travel together.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic [WIDTH-1:0] r_data  [0:gi];
            logic             r_first [0:gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j <= gi; j++) begin
                        r_data[j]  <= '0;
                        r_first[j] <= 1'b0;
                    end
                end else begin
                    r_data[0]  <= w_push_data[gi*WIDTH +: WIDTH];
                    r_first[0] <= w_push_first;
                    for (int j = 1; j <= gi; j++) begin
                        r_data[j]  <= r_data[j-1];
                        r_first[j] <= r_first[j-1];
                    end
                end
            end

            assign w_out_data[gi*WIDTH +: WIDTH] = r_data[gi];
            assign w_out_first[gi]               = r_first[gi];
        end
    endgenerate

    assign bus.out_data  = w_out_data;
    assign bus.out_first = w_out_first;
    assign bus.in_ready  = (r_state == S_LOAD);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
endmodule
